// File: rtl/jtkicker_sdram_resp.sv
// Memory-side responder for the SDRAM slot interface: BRAM-backed reads with
// configurable latency/burst, byte-lane download writes and optional refresh stalls.
module jtkicker_sdram_resp #(
  parameter int AW         = 22,
  parameter int MW         = 15,
  parameter int LATENCY    = 4,
  parameter int BURST      = 2,
  parameter int WR_LAT     = 2,
  parameter int REF_PERIOD = 0,
  parameter int REF_LEN    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          downloading,
  input  logic          sdram_req,
  input  logic [AW-1:0] sdram_addr,
  output logic          sdram_ack,
  output logic          data_dst,
  output logic          data_rdy,
  output logic [15:0]   data_read,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [7:0]    prog_data,
  input  logic [1:0]    prog_mask
);

  // state | meaning
  // IDLE  | ready to accept; refresh takes priority over requests
  // WAIT  | read accepted, counting down LATENCY before the first word
  // XFER  | returning burst words, one per cycle
  // WR    | write accepted, busy for WR_LAT cycles
  // REF   | refresh stall for REF_LEN cycles
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_XFER, S_WR, S_REF} state_t;

  localparam int CW    = 16;
  localparam int RW    = (REF_PERIOD > 1) ? $clog2(REF_PERIOD + 1) : 1;
  localparam int WR_N  = (WR_LAT  > 0) ? WR_LAT  - 1 : 0;
  localparam int REF_N = (REF_LEN > 0) ? REF_LEN - 1 : 0;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      beat_q, beat_d;
  logic [MW-1:0]   addr_q, addr_d;
  logic [RW-1:0]   ref_cnt_q, ref_cnt_d;
  logic            ack_q, ack_d;
  logic            dst_q, dst_d;
  logic            rdy_q, rdy_d;
  logic [15:0]     data_q, data_d;
  logic            ref_due;
  logic            wr_en;
  logic [1:0]      nxt_beat;
  logic [15:0]     mem [0:(1<<MW)-1];

  logic unused_addr_hi;
  assign unused_addr_hi = ^{sdram_addr[AW-1:MW], prog_addr[AW-1:MW]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    beat_d   = beat_q;
    addr_d   = addr_q;
    ack_d    = 1'b0;
    dst_d    = 1'b0;
    rdy_d    = 1'b0;
    data_d   = data_q;
    wr_en    = 1'b0;
    nxt_beat = beat_q + 2'd1;
    ref_due  = (REF_PERIOD != 0) && (ref_cnt_q == RW'(REF_PERIOD));
    if (REF_PERIOD == 0)  ref_cnt_d = '0;
    else if (ref_due)     ref_cnt_d = ref_cnt_q;
    else                  ref_cnt_d = ref_cnt_q + RW'(1);

    case (state_q)
      S_IDLE: begin
        if (ref_due) begin
          state_d   = S_REF;
          cnt_d     = CW'(REF_N);
          ref_cnt_d = '0;
        end else if (downloading && prog_we) begin
          wr_en   = 1'b1;
          ack_d   = 1'b1;
          state_d = S_WR;
          cnt_d   = CW'(WR_N);
        end else if (!downloading && sdram_req) begin
          ack_d   = 1'b1;
          addr_d  = sdram_addr[MW-1:0];
          state_d = S_WAIT;
          cnt_d   = CW'(LATENCY);
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_XFER;
          beat_d  = 2'd0;
          data_d  = mem[addr_q];
          dst_d   = 1'b1;
          rdy_d   = (BURST == 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_XFER: begin
        if (beat_q == 2'(BURST - 1)) begin
          state_d = S_IDLE;
        end else begin
          beat_d = nxt_beat;
          // address wraps naturally within the MW-bit memory space
          data_d = mem[addr_q + MW'(nxt_beat)];
          rdy_d  = (nxt_beat == 2'(BURST - 1));
        end
      end
      S_WR, S_REF: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      beat_q    <= '0;
      addr_q    <= '0;
      ref_cnt_q <= '0;
      ack_q     <= 1'b0;
      dst_q     <= 1'b0;
      rdy_q     <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      beat_q    <= beat_d;
      addr_q    <= addr_d;
      ref_cnt_q <= ref_cnt_d;
      ack_q     <= ack_d;
      dst_q     <= dst_d;
      rdy_q     <= rdy_d;
      data_q    <= data_d;
    end
  end

  // Memory has no reset so its contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      if (!prog_mask[1]) mem[prog_addr[MW-1:0]][15:8] <= prog_data;
      if (!prog_mask[0]) mem[prog_addr[MW-1:0]][7:0]  <= prog_data;
    end
  end

  assign sdram_ack = ack_q;
  assign data_dst  = dst_q;
  assign data_rdy  = rdy_q;
  assign data_read = data_q;

endmodule

// File: tb/tb_jtkicker_sdram_resp.sv
// Directed bench for jtkicker_sdram_resp: table of writes/reads plus reset,
// download-gating and refresh sequences.
module tb_jtkicker_sdram_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        downloading = 1'b0;
  logic        sdram_req = 1'b0;
  logic [21:0] sdram_addr = '0;
  logic        prog_we = 1'b0;
  logic [21:0] prog_addr = '0;
  logic [7:0]  prog_data = '0;
  logic [1:0]  prog_mask = 2'b11;

  logic        ack, dst, rdy;
  logic [15:0] dout;
  logic        ack_r, dst_r, rdy_r;
  logic [15:0] dout_r;

  int checks = 0;
  int errors = 0;

  jtkicker_sdram_resp dut (
    .clk(clk), .rst(rst), .downloading(downloading),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr),
    .sdram_ack(ack), .data_dst(dst), .data_rdy(rdy), .data_read(dout),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask)
  );

  jtkicker_sdram_resp #(.REF_PERIOD(16)) dut_r (
    .clk(clk), .rst(rst), .downloading(downloading),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr),
    .sdram_ack(ack_r), .data_dst(dst_r), .data_rdy(rdy_r), .data_read(dout_r),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [21:0] addr;
    logic [7:0]  data;
    logic [1:0]  mask;
    logic [15:0] e0;
    logic [15:0] e1;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [21:0] a, input logic [7:0] d, input logic [1:0] m);
    int acks;
    acks = 0;
    @(negedge clk);
    downloading = 1'b1; prog_we = 1'b1; prog_addr = a; prog_data = d; prog_mask = m;
    @(negedge clk);
    chk("wr_ack_first", 32'(ack), 32'd1);
    if (ack) acks++;
    prog_we = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (ack) acks++;
    end
    chk("wr_ack_count", 32'(acks), 32'd1);
  endtask

  task automatic do_read(input logic [21:0] a, input logic [15:0] e0, input logic [15:0] e1);
    int bad;
    bad = 0;
    @(negedge clk);
    downloading = 1'b0; sdram_req = 1'b1; sdram_addr = a;
    @(negedge clk);
    chk("rd_ack", 32'(ack), 32'd1);
    sdram_req = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      if (ack || dst || rdy) bad++;
    end
    @(negedge clk);
    chk("rd_beat0", 32'({dst, rdy, dout}), 32'({1'b1, 1'b0, e0}));
    @(negedge clk);
    chk("rd_beat1", 32'({dst, rdy, dout}), 32'({1'b0, 1'b1, e1}));
    @(negedge clk);
    chk("rd_after", 32'({ack, dst, rdy, dout}), 32'({3'b000, e1}));
    chk("rd_wait_quiet", 32'(bad), 32'd0);
  endtask

  initial begin
    vec_t tbl [18];
    int   n;
    int   cyc, last_ack, n_ack, n_rdy, n13, bad_gap, bad_rdy;
    tbl[0]  = '{1'b1, 22'h000100, 8'hA5, 2'b01, 16'h0000, 16'h0000};
    tbl[1]  = '{1'b1, 22'h000100, 8'h5A, 2'b10, 16'h0000, 16'h0000};
    tbl[2]  = '{1'b1, 22'h000101, 8'h12, 2'b01, 16'h0000, 16'h0000};
    tbl[3]  = '{1'b1, 22'h000101, 8'h34, 2'b10, 16'h0000, 16'h0000};
    tbl[4]  = '{1'b0, 22'h000100, 8'h00, 2'b11, 16'hA55A, 16'h1234};
    tbl[5]  = '{1'b1, 22'h000020, 8'h00, 2'b00, 16'h0000, 16'h0000};
    tbl[6]  = '{1'b1, 22'h000021, 8'h77, 2'b00, 16'h0000, 16'h0000};
    tbl[7]  = '{1'b1, 22'h000020, 8'h3C, 2'b10, 16'h0000, 16'h0000};
    tbl[8]  = '{1'b0, 22'h000020, 8'h00, 2'b11, 16'h003C, 16'h7777};
    tbl[9]  = '{1'b1, 22'h000020, 8'hC3, 2'b01, 16'h0000, 16'h0000};
    tbl[10] = '{1'b1, 22'h000020, 8'hFF, 2'b11, 16'h0000, 16'h0000};
    tbl[11] = '{1'b0, 22'h000020, 8'h00, 2'b11, 16'hC33C, 16'h7777};
    tbl[12] = '{1'b1, 22'h007FFF, 8'hBE, 2'b00, 16'h0000, 16'h0000};
    tbl[13] = '{1'b1, 22'h000000, 8'hEF, 2'b00, 16'h0000, 16'h0000};
    tbl[14] = '{1'b0, 22'h007FFF, 8'h00, 2'b11, 16'hBEBE, 16'hEFEF};
    tbl[15] = '{1'b0, 22'h3F8100, 8'h00, 2'b11, 16'hA55A, 16'h1234};
    tbl[16] = '{1'b1, 22'h208020, 8'h11, 2'b10, 16'h0000, 16'h0000};
    tbl[17] = '{1'b0, 22'h000020, 8'h00, 2'b11, 16'hC311, 16'h7777};

    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({ack, dst, rdy, dout}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", 32'({ack, dst, rdy, dout}), 32'd0);

    for (int i = 0; i < 18; i++) begin
      if (tbl[i].wr) do_write(tbl[i].addr, tbl[i].data, tbl[i].mask);
      else           do_read(tbl[i].addr, tbl[i].e0, tbl[i].e1);
    end

    // prog_we without downloading must be ignored
    n = 0;
    @(negedge clk);
    downloading = 1'b0; prog_we = 1'b1; prog_addr = 22'h100; prog_data = 8'h00; prog_mask = 2'b00;
    repeat (10) begin
      @(negedge clk);
      if (ack) n++;
    end
    prog_we = 1'b0;
    chk("we_ignored_no_ack", 32'(n), 32'd0);
    do_read(22'h100, 16'hA55A, 16'h1234);

    // sdram_req while downloading must be ignored
    n = 0;
    @(negedge clk);
    downloading = 1'b1; sdram_req = 1'b1; sdram_addr = 22'h100;
    repeat (50) begin
      @(negedge clk);
      if (ack) n++;
    end
    sdram_req = 1'b0; downloading = 1'b0;
    chk("req_ignored_dl", 32'(n), 32'd0);

    // reset asserted during WAIT aborts the read
    @(negedge clk);
    sdram_req = 1'b1; sdram_addr = 22'h101;
    @(negedge clk);
    chk("rst_seq_ack", 32'(ack), 32'd1);
    sdram_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_wait", 32'({ack, dst, rdy, dout}), 32'd0);
    rst = 1'b0;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (ack || dst || rdy) n++;
    end
    chk("rst_abort_quiet", 32'(n), 32'd0);
    do_read(22'h100, 16'hA55A, 16'h1234);

    // refresh instance: requests held high, acks must avoid refresh windows
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    downloading = 1'b0; sdram_req = 1'b1; sdram_addr = 22'h100;
    cyc = 0; last_ack = -1; n_ack = 0; n_rdy = 0; n13 = 0; bad_gap = 0; bad_rdy = 0;
    for (int t = 0; t < 230; t++) begin
      @(negedge clk);
      cyc++;
      if (t == 200) sdram_req = 1'b0;
      if (ack_r) begin
        if (last_ack >= 0) begin
          if (cyc - last_ack == 13) n13++;
          else if (cyc - last_ack != 8) bad_gap++;
        end
        last_ack = cyc;
        n_ack++;
      end
      if (rdy_r) begin
        n_rdy++;
        if (cyc - last_ack != 6) bad_rdy++;
      end
    end
    chk("ref_gap_bad", 32'(bad_gap), 32'd0);
    chk("ref_windows_seen", 32'(n13 > 0), 32'd1);
    chk("ref_rdy_timing", 32'(bad_rdy), 32'd0);
    chk("ref_every_read_rdy", 32'(n_rdy), 32'(n_ack));
    chk("ref_reads_made", 32'(n_ack > 10), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
